// File: rtl/memory_stage.sv
// Memory access stage. It issues data-memory commands for loads and stores and
// holds the pipeline while an access is outstanding. Results go to writeback in registers.
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_branch_hazard,
  input  logic [31:0] input_reg_pc,
  input  logic [31:0] input_alu_out,
  input  logic [31:0] input_rs2_data,
  input  logic [31:0] input_op1_data,
  input  logic [31:0] input_imm_i,
  input  logic [3:0]  input_mem_wen,
  input  logic        input_rf_wen,
  input  logic [3:0]  input_wb_sel,
  input  logic [4:0]  input_wb_addr,
  input  logic [2:0]  input_csr_cmd,
  input  logic        input_jmp_flg,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic        mem_cmd_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rdata_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] output_reg_pc,
  output logic [31:0] output_alu_out,
  output logic [31:0] output_mem_rdata,
  output logic [31:0] output_op1_data,
  output logic [31:0] output_imm_i,
  output logic        output_rf_wen,
  output logic [3:0]  output_wb_sel,
  output logic [4:0]  output_wb_addr,
  output logic [2:0]  output_csr_cmd,
  output logic        output_jmp_flg,
  output logic        output_misaligned,
  output logic        output_stall_flg
);

  localparam logic [3:0] MEN_X  = 4'd0;
  localparam logic [3:0] MEN_SB = 4'd1;
  localparam logic [3:0] MEN_SH = 4'd2;
  localparam logic [3:0] MEN_SW = 4'd3;
  localparam logic [3:0] WB_X   = 4'd0;
  localparam logic [3:0] WB_LB  = 4'd4;
  localparam logic [3:0] WB_LBU = 4'd5;
  localparam logic [3:0] WB_LH  = 4'd6;
  localparam logic [3:0] WB_LHU = 4'd7;
  localparam logic [3:0] WB_LW  = 4'd8;
  localparam logic [2:0] CSR_X  = 3'd0;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_READY = 2'd1, WAIT_RDATA = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] reg_pc;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic [31:0] op1_data;
    logic [31:0] imm_i;
    logic [3:0]  mem_wen;
    logic        rf_wen;
    logic [3:0]  wb_sel;
    logic [4:0]  wb_addr;
    logic [2:0]  csr_cmd;
    logic        jmp_flg;
  } op_t;

  typedef struct packed {
    logic [31:0] reg_pc;
    logic [31:0] alu_out;
    logic [31:0] mem_rdata;
    logic [31:0] op1_data;
    logic [31:0] imm_i;
    logic        rf_wen;
    logic [3:0]  wb_sel;
    logic [4:0]  wb_addr;
    logic [2:0]  csr_cmd;
    logic        jmp_flg;
    logic        misaligned;
  } out_t;

  // Access size code: 0 none, 1 byte, 2 half, 3 word. Store decode wins over load decode.
  function automatic logic [1:0] access_size(input logic [3:0] mem_wen, input logic [3:0] wb_sel);
    logic [1:0] sz;
    case (mem_wen)
      MEN_SB: sz = 2'd1;
      MEN_SH: sz = 2'd2;
      MEN_SW: sz = 2'd3;
      MEN_X: begin
        case (wb_sel)
          WB_LB, WB_LBU: sz = 2'd1;
          WB_LH, WB_LHU: sz = 2'd2;
          WB_LW:         sz = 2'd3;
          default:       sz = 2'd0;
        endcase
      end
      default: sz = 2'd0;
    endcase
    return sz;
  endfunction

  function automatic logic is_store(input logic [3:0] mem_wen);
    logic st;
    case (mem_wen)
      MEN_SB, MEN_SH, MEN_SW: st = 1'b1;
      default:                st = 1'b0;
    endcase
    return st;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic mis;
    case (sz)
      2'd2:    mis = off[0];
      2'd3:    mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_mask(input logic [3:0] mem_wen, input logic [1:0] off);
    logic [3:0] m;
    case (mem_wen)
      MEN_SB:  m = 4'b0001 << off;
      MEN_SH:  m = 4'b0011 << off;
      MEN_SW:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] mem_wen, input logic [31:0] rs2);
    logic [31:0] d;
    case (mem_wen)
      MEN_SB:  d = {4{rs2[7:0]}};
      MEN_SH:  d = {2{rs2[15:0]}};
      MEN_SW:  d = rs2;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [3:0] wb_sel, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [15:0] half;
    logic [7:0]  byt;
    logic [31:0] res;
    half = off[1] ? rdata[31:16] : rdata[15:0];
    byt  = off[0] ? half[15:8] : half[7:0];
    case (wb_sel)
      WB_LB:   res = {{24{byt[7]}}, byt};
      WB_LBU:  res = {24'h00_0000, byt};
      WB_LH:   res = {{16{half[15]}}, half};
      WB_LHU:  res = {16'h0000, half};
      WB_LW:   res = rdata;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  function automatic out_t bubble();
    out_t b;
    b = '0;
    b.reg_pc  = 32'hFFFF_FFFF;
    b.wb_sel  = WB_X;
    b.csr_cmd = CSR_X;
    return b;
  endfunction

  function automatic out_t writeback(input op_t op, input logic mis, input logic [31:0] rdata);
    out_t w;
    w.reg_pc     = op.reg_pc;
    w.alu_out    = op.alu_out;
    w.mem_rdata  = rdata;
    w.op1_data   = op.op1_data;
    w.imm_i      = op.imm_i;
    w.rf_wen     = op.rf_wen & ~mis;
    w.wb_sel     = op.wb_sel;
    w.wb_addr    = op.wb_addr;
    w.csr_cmd    = op.csr_cmd;
    w.jmp_flg    = op.jmp_flg;
    w.misaligned = mis;
    return w;
  endfunction

  state_t     state_r, state_nxt_s;
  op_t        in_op_s, save_r, cur_op_s;
  out_t       out_r, out_nxt_s;
  logic       squash_r, squash_nxt_s;
  logic [1:0] cur_size_s, cur_off_s;
  logic       cur_store_s, cur_mem_s, cur_misaligned_s;
  logic       issue_s, stall_s;

  assign in_op_s = {input_reg_pc, input_alu_out, input_rs2_data, input_op1_data, input_imm_i,
                    input_mem_wen, input_rf_wen, input_wb_sel, input_wb_addr, input_csr_cmd,
                    input_jmp_flg};

  // In IDLE the live inputs describe the op; afterwards the latched copy does.
  assign cur_op_s         = (state_r == IDLE) ? in_op_s : save_r;
  assign cur_size_s       = access_size(cur_op_s.mem_wen, cur_op_s.wb_sel);
  assign cur_off_s        = cur_op_s.alu_out[1:0];
  assign cur_store_s      = is_store(cur_op_s.mem_wen);
  assign cur_mem_s        = (cur_size_s != 2'd0);
  assign cur_misaligned_s = is_misaligned(cur_size_s, cur_off_s);

  assign mem_cmd_valid    = issue_s & ~rst;
  assign output_stall_flg = stall_s & ~rst;
  assign mem_cmd_write    = cur_store_s;
  assign mem_addr         = {cur_op_s.alu_out[31:2], 2'b00};
  assign mem_wmask        = store_mask(cur_op_s.mem_wen, cur_off_s);
  assign mem_wdata        = store_data(cur_op_s.mem_wen, cur_op_s.rs2_data);

  // State register plus the squash flag for a load flushed while waiting for data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      squash_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      squash_r <= squash_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s  = state_r;
    squash_nxt_s = 1'b0;
    case (state_r)
      IDLE, WAIT_READY: begin
        if (!issue_s)            state_nxt_s = IDLE;
        else if (!mem_cmd_ready) state_nxt_s = WAIT_READY;
        else if (cur_store_s)    state_nxt_s = IDLE;
        else                     state_nxt_s = WAIT_RDATA;
      end
      WAIT_RDATA: begin
        if (mem_rdata_valid) begin
          state_nxt_s  = IDLE;
          squash_nxt_s = 1'b0;
        end else begin
          state_nxt_s  = WAIT_RDATA;
          squash_nxt_s = squash_r | wb_branch_hazard;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Command issue and stall; a hazard in WAIT_READY withdraws the command.
  always_comb begin
    issue_s = 1'b0;
    stall_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!wb_branch_hazard && cur_mem_s && !cur_misaligned_s) begin
          issue_s = 1'b1;
          stall_s = !cur_store_s || !mem_cmd_ready;
        end else begin
          issue_s = 1'b0;
          stall_s = 1'b0;
        end
      end
      WAIT_READY: begin
        if (wb_branch_hazard) begin
          issue_s = 1'b0;
          stall_s = 1'b0;
        end else begin
          issue_s = 1'b1;
          stall_s = !cur_store_s || !mem_cmd_ready;
        end
      end
      WAIT_RDATA: begin
        issue_s = 1'b0;
        stall_s = !mem_rdata_valid;
      end
      default: begin
        issue_s = 1'b0;
        stall_s = 1'b0;
      end
    endcase
  end

  // Writeback bundle selection: bubble, pass-through, or load completion.
  always_comb begin
    out_nxt_s = bubble();
    if (stall_s) begin
      out_nxt_s = bubble();
    end else begin
      case (state_r)
        IDLE: begin
          if (wb_branch_hazard) out_nxt_s = bubble();
          else                  out_nxt_s = writeback(cur_op_s, cur_misaligned_s, 32'h0000_0000);
        end
        WAIT_READY: begin
          if (wb_branch_hazard) out_nxt_s = bubble();
          else                  out_nxt_s = writeback(cur_op_s, 1'b0, 32'h0000_0000);
        end
        WAIT_RDATA: begin
          if (squash_r || wb_branch_hazard) out_nxt_s = bubble();
          else out_nxt_s = writeback(cur_op_s, 1'b0,
                                     load_extend(cur_op_s.wb_sel, cur_off_s, mem_rdata));
        end
        default: out_nxt_s = bubble();
      endcase
    end
  end

  // Save registers and writeback output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      save_r <= '0;
      out_r  <= bubble();
    end else begin
      if (state_r == IDLE && issue_s) save_r <= in_op_s;
      out_r <= out_nxt_s;
    end
  end

  assign output_reg_pc     = out_r.reg_pc;
  assign output_alu_out    = out_r.alu_out;
  assign output_mem_rdata  = out_r.mem_rdata;
  assign output_op1_data   = out_r.op1_data;
  assign output_imm_i      = out_r.imm_i;
  assign output_rf_wen     = out_r.rf_wen;
  assign output_wb_sel     = out_r.wb_sel;
  assign output_wb_addr    = out_r.wb_addr;
  assign output_csr_cmd    = out_r.csr_cmd;
  assign output_jmp_flg    = out_r.jmp_flg;
  assign output_misaligned = out_r.misaligned;

endmodule
